// File: rtl/measurement_frame_parser.sv
// Byte-stream front end: opcode/header recognition and per-round
// deserialisation of syndrome payload onto a valid/ready round port.
module measurement_frame_parser #(
  parameter int GRID_WIDTH_X = 14,
  parameter int GRID_WIDTH_Z = 6,
  parameter int MEASUREMENT_ROUNDS = 12,
  parameter logic [7:0] START_DECODING_MSG = 8'h01,
  parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02,
  localparam int PU_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int BYTES_PER_ROUND = (PU_PER_ROUND + 7) >> 3,
  localparam int ROUND_W = $clog2(MEASUREMENT_ROUNDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              input_data,
  input  logic                    input_valid,
  output logic                    input_ready,
  output logic [PU_PER_ROUND-1:0] round_data,
  output logic                    round_valid,
  input  logic                    round_ready,
  output logic [ROUND_W-1:0]      round_index,
  output logic                    round_last,
  output logic                    decoding_enabled,
  output logic                    protocol_error,
  output logic [7:0]              error_count
);

  localparam int BCW = $clog2(BYTES_PER_ROUND + 1);
  // One spare byte so {byte_cnt,3'b000} indexes the register exactly
  localparam int ASM_W = 8 * (BYTES_PER_ROUND + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_HDR = 2'd1;
  localparam logic [1:0] LOAD     = 2'd2;
  localparam logic [1:0] EMIT     = 2'd3;

  logic [1:0]         state;
  logic [BCW-1:0]     byte_cnt;
  logic [ROUND_W-1:0] round_cnt;
  logic [ASM_W-1:0]   asm_q;
  logic [ASM_W-1:0]   asm_nxt;
  logic               take;
  logic               last_byte;
  logic               is_start;
  logic               is_hdr;
  logic               err_now;

  assign input_ready = (state != EMIT);
  assign take = input_valid && input_ready;
  assign last_byte = (byte_cnt == BCW'(BYTES_PER_ROUND - 1));
  assign is_start = (input_data == START_DECODING_MSG);
  assign is_hdr = (input_data == MEASUREMENT_DATA_HEADER);

  always_comb begin
    err_now = 1'b0;
    if (take) begin
      unique case (1'b1)
        (state == IDLE):     err_now = !is_start;
        (state == WAIT_HDR): err_now = !is_hdr && !is_start;
        default:             err_now = 1'b0;
      endcase
    end
  end

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{byte_cnt, 3'b000} +: 8] = input_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      byte_cnt         <= '0;
      round_cnt        <= '0;
      asm_q            <= '0;
      round_data       <= '0;
      round_valid      <= 1'b0;
      round_index      <= '0;
      round_last       <= 1'b0;
      decoding_enabled <= 1'b0;
      protocol_error   <= 1'b0;
      error_count      <= 8'h00;
    end else begin
      protocol_error <= err_now;
      if (err_now && error_count != 8'hFF) begin
        error_count <= error_count + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (take && is_start) begin
            decoding_enabled <= 1'b1;
            state            <= WAIT_HDR;
          end
        end
        WAIT_HDR: begin
          if (take && is_hdr) begin
            byte_cnt  <= '0;
            round_cnt <= '0;
            asm_q     <= '0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (take) begin
            asm_q <= asm_nxt;
            if (last_byte) begin
              round_data  <= asm_nxt[PU_PER_ROUND-1:0];
              round_index <= round_cnt;
              round_last  <= (round_cnt == ROUND_W'(MEASUREMENT_ROUNDS - 1));
              round_valid <= 1'b1;
              state       <= EMIT;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        EMIT: begin
          if (round_ready) begin
            round_valid <= 1'b0;
            if (round_last) begin
              state <= WAIT_HDR;
            end else begin
              round_cnt <= round_cnt + ROUND_W'(1);
              byte_cnt  <= '0;
              state     <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
